ttt_game_ctrl: RTL

//  Game sequencer for the tic-tac-toe board. Accepts debounced "place" requests for the cursor square
//  (square_num from the rotary cursor logic). Owns the 9-square board state, the turn, and win/draw

---
 rtl/ttt_pkg.sv | 54 +++++
 rtl/ttt_win_detect.sv | 20 ++
 rtl/ttt_game_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/ttt_pkg.sv
// rtl/ttt_pkg.sv - shared square/cell/state encodings and the win-line table for the tic-tac-toe controller
package ttt_pkg;

  typedef enum logic [7:0] {
    NO_SQUARE = 8'd0,
    SQUARE_1  = 8'd1,
    SQUARE_2  = 8'd2,
    SQUARE_3  = 8'd3,
    SQUARE_4  = 8'd4,
    SQUARE_5  = 8'd5,
    SQUARE_6  = 8'd6,
    SQUARE_7  = 8'd7,
    SQUARE_8  = 8'd8,
    SQUARE_9  = 8'd9
  } square_t;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_P1    = 2'b01,
    CELL_P2    = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int NUM_LINES = 8;

  // Square numbers (1-based) of each row, column and diagonal.
  localparam logic [3:0] WIN_LINES [NUM_LINES][3] = '{
    '{4'd1, 4'd2, 4'd3},
    '{4'd4, 4'd5, 4'd6},
    '{4'd7, 4'd8, 4'd9},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd3, 4'd6, 4'd9},
    '{4'd1, 4'd5, 4'd9},
    '{4'd3, 4'd5, 4'd7}
  };

  function automatic logic square_legal(input logic [7:0] sq);
    return (sq >= SQUARE_1) && (sq <= SQUARE_9);
  endfunction

  // Square k lives at board[2k-1:2k-2]; the shift {k-1,0} is 2*(k-1).
  function automatic logic [1:0] cell_at(input logic [17:0] board, input logic [3:0] sq);
    logic [17:0] shifted;
    shifted = board >> {sq - 4'd1, 1'b0};
    return shifted[1:0];
  endfunction

endpackage

// File: rtl/ttt_win_detect.sv
// rtl/ttt_win_detect.sv - combinational three-in-a-row detector for one cell code
module ttt_win_detect
  import ttt_pkg::*;
(
  input  logic [17:0] board_state,
  input  cell_t       code,
  output logic        line_found
);

  logic [NUM_LINES-1:0] hits;

  for (genvar l = 0; l < NUM_LINES; l++) begin : g_line
    assign hits[l] = (cell_at(board_state, WIN_LINES[l][0]) == code) &&
                     (cell_at(board_state, WIN_LINES[l][1]) == code) &&
                     (cell_at(board_state, WIN_LINES[l][2]) == code);
  end

  assign line_found = |hits;

endmodule

// File: rtl/ttt_game_ctrl.sv
// rtl/ttt_game_ctrl.sv - tic-tac-toe game sequencer: board, turn, move count, win/draw detection
// Optional per-move forfeit timer enabled by defining TTT_TURN_TIMER_EN.
module ttt_game_ctrl
  import ttt_pkg::*;
#(
  parameter logic        START_PLAYER = 1'b0,
  parameter logic [31:0] TURN_TIMEOUT = 32'd250_000_000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [7:0]  square_num,
  input  logic        place,
  input  logic        new_game,
  output logic [17:0] board_state,
  output logic        cur_player,
  output logic [3:0]  move_count,
  output logic        illegal_move,
  output logic        game_over,
  output logic        player_1_win,
  output logic        player_2_win,
  output logic        draw,
  output logic        turn_timeout
);

  state_t      state, state_nxt;
  logic [17:0] board_nxt;
  logic        cur_nxt;
  logic [3:0]  count_nxt;
  logic        illegal_nxt, p1_nxt, p2_nxt, draw_nxt, timeout_nxt;
  logic        sq_ok, accept, timer_expired, line_found;
  logic [3:0]  sq_idx;
  cell_t       mover;

  assign sq_idx = square_num[3:0];
  assign mover  = cur_player ? CELL_P2 : CELL_P1;
  assign sq_ok  = square_legal(square_num) && (cell_at(board_state, sq_idx) == CELL_EMPTY);
  assign accept = (state == ST_PLAY) && place && !new_game && sq_ok;

  // The board already holds the mover's piece when CHECK evaluates it.
  ttt_win_detect u_win_detect (
    .board_state (board_state),
    .code        (mover),
    .line_found  (line_found)
  );

  always_comb begin
    state_nxt   = state;
    board_nxt   = board_state;
    cur_nxt     = cur_player;
    count_nxt   = move_count;
    illegal_nxt = 1'b0;
    p1_nxt      = player_1_win;
    p2_nxt      = player_2_win;
    draw_nxt    = draw;
    timeout_nxt = 1'b0;
    if (new_game) begin
      state_nxt = ST_PLAY;
      board_nxt = '0;
      cur_nxt   = START_PLAYER;
      count_nxt = '0;
      p1_nxt    = 1'b0;
      p2_nxt    = 1'b0;
      draw_nxt  = 1'b0;
    end else begin
      case (state)
        ST_PLAY: begin
          illegal_nxt = place && !sq_ok;
          if (accept) begin
            board_nxt = board_state | ({16'd0, mover} << {sq_idx - 4'd1, 1'b0});
            count_nxt = (move_count == 4'd9) ? move_count : move_count + 4'd1;
            state_nxt = ST_CHECK;
          end else if (timer_expired) begin
            cur_nxt     = ~cur_player;
            timeout_nxt = 1'b1;
          end
        end
        ST_CHECK: begin
          if (line_found) begin
            state_nxt = ST_DONE;
            p1_nxt    = ~cur_player;
            p2_nxt    = cur_player;
          end else if (move_count == 4'd9) begin
            state_nxt = ST_DONE;
            draw_nxt  = 1'b1;
          end else begin
            state_nxt = ST_PLAY;
            cur_nxt   = ~cur_player;
          end
        end
        ST_DONE: begin
        end
        default: state_nxt = ST_PLAY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state        <= ST_PLAY;
      board_state  <= '0;
      cur_player   <= START_PLAYER;
      move_count   <= '0;
      illegal_move <= 1'b0;
      player_1_win <= 1'b0;
      player_2_win <= 1'b0;
      draw         <= 1'b0;
    end else begin
      state        <= state_nxt;
      board_state  <= board_nxt;
      cur_player   <= cur_nxt;
      move_count   <= count_nxt;
      illegal_move <= illegal_nxt;
      player_1_win <= p1_nxt;
      player_2_win <= p2_nxt;
      draw         <= draw_nxt;
    end
  end

  assign game_over = (state == ST_DONE);

`ifdef TTT_TURN_TIMER_EN
  logic [31:0] turn_timer;

  // Zero outside PLAY, so entering PLAY always starts a fresh count.
  always_ff @(posedge clk) begin
    if (clr || (state != ST_PLAY) || (state_nxt != ST_PLAY) || new_game || timeout_nxt) begin
      turn_timer <= '0;
    end else begin
      turn_timer <= turn_timer + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      turn_timeout <= 1'b0;
    end else begin
      turn_timeout <= timeout_nxt;
    end
  end

  assign timer_expired = (turn_timer == TURN_TIMEOUT - 32'd1);
`else
  logic unused_timer_cfg;
  assign unused_timer_cfg = ^{TURN_TIMEOUT, timeout_nxt};
  assign timer_expired    = 1'b0;
  assign turn_timeout     = 1'b0;
`endif

endmodule
